ramio_arbiter: RTL

RAMIO_ARBITER -- requirements
Module: ramio_arbiter

---
 rtl/ramio_arbiter_pkg.sv | 24 ++
 rtl/ramio_arbiter_if.sv | 32 +++
 rtl/ramio_arbiter_rr_pick.sv | 19 +
 rtl/ramio_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ramio_arbiter_pkg.sv
// Shared definitions for the RAMIO arbiter: FSM state encoding and the
// RAMIO command type constants also used by the Core.
package ramio_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam logic [1:0] WT_NONE = 2'd0;
   localparam logic [1:0] WT_BYTE = 2'd1;
   localparam logic [1:0] WT_HALF = 2'd2;
   localparam logic [1:0] WT_WORD = 2'd3;

   localparam logic [2:0] RT_NONE = 3'd0;

   // A command is a read only when it carries no write; mixed commands write.
   function automatic logic is_read_cmd(input logic [1:0] wt, input logic [2:0] rt);
      return (wt == WT_NONE) && (rt != RT_NONE);
   endfunction

endpackage

// File: rtl/ramio_arbiter_if.sv
// Requester-side and RAMIO-side bundles of the RAMIO arbiter.
interface ramio_req_if;
   logic        req;
   logic [1:0]  write_type;
   logic [2:0]  read_type;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ack;
   logic        err;

   modport master (output req, write_type, read_type, address, data_in,
                   input  data_out, ack, err);
   modport slave  (input  req, write_type, read_type, address, data_in,
                   output data_out, ack, err);
endinterface

interface ramio_mem_if;
   logic        enable;
   logic [1:0]  write_type;
   logic [2:0]  read_type;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic        busy;

   modport master (output enable, write_type, read_type, address, data_in,
                   input  data_out, data_out_ready, busy);
   modport slave  (input  enable, write_type, read_type, address, data_in,
                   output data_out, data_out_ready, busy);
endinterface

// File: rtl/ramio_arbiter_rr_pick.sv
// Two-way round-robin pick; the last-grant pointer lives in the parent.
module ramio_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_req,
   output logic pick
);

   assign any_req = req0 | req1;

   always_comb begin
      pick = req1;
      if (req0 && req1) begin
         pick = ~last_grant;
      end
   end

endmodule

// File: rtl/ramio_arbiter.sv
// Arbitrates two requesters onto a single RAMIO port, one command at a time,
// with a per-command completion timeout.
module ramio_arbiter
   import ramio_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES   = 4096,
   parameter int TIMEOUT_BITWIDTH = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   ramio_req_if.slave   m0,
   ramio_req_if.slave   m1,
   ramio_mem_if.master  ramio,
   output logic         grant
);

   localparam logic [TIMEOUT_BITWIDTH-1:0] TO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

   arb_state_t state, state_nxt;

   logic                        rr_last;
   logic                        any_req;
   logic                        pick;
   logic [TIMEOUT_BITWIDTH-1:0] to_cnt;
   logic                        cmd_is_read;
   logic [1:0]                  cmd_wt;
   logic [2:0]                  cmd_rt;
   logic [31:0]                 cmd_addr;
   logic [31:0]                 cmd_data;
   logic                        err_q;
   logic [31:0]                 data_out0;
   logic [31:0]                 data_out1;

   logic [1:0]                  sel_wt;
   logic [2:0]                  sel_rt;
   logic [31:0]                 sel_addr;
   logic [31:0]                 sel_data;
   logic                        accept;
   logic                        done_ok;
   logic                        done_to;

   ramio_rr_pick u_rr_pick (
      .req0       (m0.req),
      .req1       (m1.req),
      .last_grant (rr_last),
      .any_req    (any_req),
      .pick       (pick)
   );

   always_comb begin
      sel_wt   = pick ? m1.write_type : m0.write_type;
      sel_rt   = pick ? m1.read_type  : m0.read_type;
      sel_addr = pick ? m1.address    : m0.address;
      sel_data = pick ? m1.data_in    : m0.data_in;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req && !ramio.busy) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // Normal completion wins over a timeout landing in the same cycle.
            if (cmd_is_read ? ramio.data_out_ready : !ramio.busy) begin
               done_ok   = 1'b1;
               state_nxt = ST_DONE;
            end else if (to_cnt == TO_LAST) begin
               done_to   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= 1'b0;
         rr_last     <= 1'b1;
         cmd_is_read <= 1'b0;
         cmd_wt      <= WT_NONE;
         cmd_rt      <= RT_NONE;
         cmd_addr    <= '0;
         cmd_data    <= '0;
         to_cnt      <= '0;
         err_q       <= 1'b0;
         data_out0   <= '0;
         data_out1   <= '0;
      end else begin
         if (accept) begin
            grant       <= pick;
            rr_last     <= pick;
            cmd_is_read <= is_read_cmd(sel_wt, sel_rt);
            cmd_wt      <= sel_wt;
            cmd_rt      <= is_read_cmd(sel_wt, sel_rt) ? sel_rt : RT_NONE;
            cmd_addr    <= sel_addr;
            cmd_data    <= sel_data;
         end
         if (state == ST_ISSUE) begin
            to_cnt <= '0;
         end else if (state == ST_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (done_ok || done_to) begin
            err_q <= done_to;
         end
         if (done_ok && cmd_is_read) begin
            if (grant) begin
               data_out1 <= ramio.data_out;
            end else begin
               data_out0 <= ramio.data_out;
            end
         end
      end
   end

   assign ramio.enable     = (state == ST_ISSUE);
   assign ramio.write_type = cmd_wt;
   assign ramio.read_type  = cmd_rt;
   assign ramio.address    = cmd_addr;
   assign ramio.data_in    = cmd_data;

   assign m0.ack      = (state == ST_DONE) && !grant;
   assign m1.ack      = (state == ST_DONE) && grant;
   assign m0.err      = m0.ack && err_q;
   assign m1.err      = m1.ack && err_q;
   assign m0.data_out = data_out0;
   assign m1.data_out = data_out1;

endmodule
